// File: rtl/control_sequencer.sv
// control_sequencer: microcoded Moore sequencer producing the 32-bit data_path
// control word (fetch, decode, DP / load-store / branch execute).
// Optional MFC timeout to a sticky FAULT state: define CU_MFC_TIMEOUT_EN.
module control_sequencer #(
  parameter int unsigned MFC_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [31:0] IR_Out,
  input  logic        MFC,
  input  logic [3:0]  Flags,
  output logic [31:0] CW,
  output logic [4:0]  STATE,
  output logic        FAULT
);

  localparam int unsigned CNT_W = 5;

  // Control word field layout, MSB first.
  typedef struct packed {
    logic       mfa;
    logic       rw_ram;
    logic       salu;
    logic       rf_rw;
    logic       ssab;
    logic       ssop;
    logic       sma;
    logic       sta;
    logic       mar_en;
    logic       sr_en;
    logic       mdr_en;
    logic       ir_en;
    logic       sht_en;
    logic       ise_en;
    logic       sgn_en;
    logic       clr_n;
    logic [1:0] dss;
    logic [1:0] wra;
    logic [1:0] sra;
    logic [1:0] srb;
    logic [1:0] sise;
    logic [1:0] salub;
    logic [3:0] alua;
  } cw_t;

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH_MAR  = 5'd1,
    S_FETCH_READ = 5'd2,
    S_FETCH_IR   = 5'd3,
    S_PC_INC     = 5'd4,
    S_DECODE     = 5'd5,
    S_DP_EXEC    = 5'd6,
    S_LS_ADDR    = 5'd7,
    S_LS_READ    = 5'd8,
    S_LS_LOAD    = 5'd9,
    S_LS_WRITE   = 5'd10,
    S_BR_EXEC    = 5'd11,
    S_FAULT      = 5'd12
  } state_t;

  localparam cw_t IDLE_CW       = cw_t'(32'h10F1_0000);
  localparam cw_t RESET_CW      = cw_t'(32'h00F0_0000);
  localparam cw_t FETCH_MAR_CW  = cw_t'(32'h1471_013D);
  localparam cw_t FETCH_READ_CW = cw_t'(32'hC0F1_8000);
  localparam cw_t FETCH_IR_CW   = cw_t'(32'h02C1_0000);
  localparam cw_t PC_INC_CW     = cw_t'(32'h00F1_1414);

  state_t state;
  state_t state_next;
  cw_t    cw;
  logic   cond_ok;

  // ARM condition-code evaluation against {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flg);
    logic n;
    logic z;
    logic c;
    logic v;
    logic p;
    n = flg[3];
    z = flg[2];
    c = flg[1];
    v = flg[0];
    case (cond)
      4'b0000: p = z;
      4'b0001: p = ~z;
      4'b0010: p = c;
      4'b0011: p = ~c;
      4'b0100: p = n;
      4'b0101: p = ~n;
      4'b0110: p = v;
      4'b0111: p = ~v;
      4'b1000: p = c & ~z;
      4'b1001: p = ~c | z;
      4'b1010: p = (n == v);
      4'b1011: p = (n != v);
      4'b1100: p = ~z & (n == v);
      4'b1101: p = z | (n != v);
      4'b1110: p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  // Condition outcome used only by DECODE.
  always_comb begin
    cond_ok = cond_pass(IR_Out[31:28], Flags);
  end

`ifdef CU_MFC_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             timeout_hit;
  logic             fault_q;

  // Timeout fires on the cycle the MFC-low count would reach the limit.
  always_comb begin
    in_wait     = (state == S_FETCH_READ) || (state == S_LS_READ) ||
                  (state == S_LS_WRITE);
    timeout_hit = in_wait && !MFC &&
                  ((wait_cnt + CNT_W'(1)) == CNT_W'(MFC_TIMEOUT));
  end

  // Wait-cycle counter: cleared on every state change, counts MFC-low cycles.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (in_wait && !MFC) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Sticky fault flag, cleared only by CLR.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      fault_q <= 1'b0;
    end else if (state_next == S_FAULT) begin
      fault_q <= 1'b1;
    end
  end

  assign FAULT = fault_q;

  logic unused_ir;
  assign unused_ir = ^IR_Out[19:0];
`else
  logic timeout_hit;
  assign timeout_hit = 1'b0;
  assign FAULT       = 1'b0;

  logic unused_ir;
  assign unused_ir = ^{IR_Out[19:0], CNT_W'(MFC_TIMEOUT)};
`endif

  // State register.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= S_RESET;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Moore control-word decode.
  always_comb begin
    state_next = state;
    cw         = IDLE_CW;
    case (state)
      S_RESET: begin
        cw         = RESET_CW;
        state_next = S_FETCH_MAR;
      end
      S_FETCH_MAR: begin
        cw         = FETCH_MAR_CW;
        state_next = S_FETCH_READ;
      end
      S_FETCH_READ: begin
        cw = FETCH_READ_CW;
        if (MFC) begin
          state_next = S_FETCH_IR;
        end else if (timeout_hit) begin
          state_next = S_FAULT;
        end
      end
      S_FETCH_IR: begin
        cw         = FETCH_IR_CW;
        state_next = S_PC_INC;
      end
      S_PC_INC: begin
        cw         = PC_INC_CW;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next = S_FETCH_MAR;
        if (cond_ok) begin
          case (IR_Out[27:25])
            3'b000, 3'b001: state_next = S_DP_EXEC;
            3'b010:         state_next = S_LS_ADDR;
            3'b101:         state_next = S_BR_EXEC;
            default:        state_next = S_FETCH_MAR;
          endcase
        end
      end
      S_DP_EXEC: begin
        cw.alua    = IR_Out[24:21];
        cw.salub   = IR_Out[25] ? 2'b10 : 2'b00;
        cw.rf_rw   = (IR_Out[24:23] == 2'b10);
        cw.sr_en   = ~IR_Out[20];
        state_next = S_FETCH_MAR;
      end
      S_LS_ADDR: begin
        cw.alua    = IR_Out[23] ? 4'b0100 : 4'b0010;
        cw.salub   = 2'b10;
        cw.mar_en  = 1'b0;
        state_next = IR_Out[20] ? S_LS_READ : S_LS_WRITE;
      end
      S_LS_READ: begin
        cw.mfa    = 1'b1;
        cw.rw_ram = 1'b1;
        cw.mdr_en = 1'b0;
        if (MFC) begin
          state_next = S_LS_LOAD;
        end else if (timeout_hit) begin
          state_next = S_FAULT;
        end
      end
      S_LS_LOAD: begin
        cw.rf_rw   = 1'b0;
        cw.dss     = 2'b01;
        cw.alua    = 4'b1101;
        cw.salub   = 2'b01;
        state_next = S_FETCH_MAR;
      end
      S_LS_WRITE: begin
        cw.mfa    = 1'b1;
        cw.rw_ram = 1'b0;
        cw.sma    = 1'b1;
        if (MFC) begin
          state_next = S_FETCH_MAR;
        end else if (timeout_hit) begin
          state_next = S_FAULT;
        end
      end
      S_BR_EXEC: begin
        cw.rf_rw   = 1'b0;
        cw.wra     = 2'b01;
        cw.sra     = 2'b01;
        cw.salub   = 2'b10;
        cw.alua    = 4'b0100;
        cw.sgn_en  = 1'b1;
        state_next = S_FETCH_MAR;
      end
      S_FAULT: begin
        state_next = S_FAULT;
      end
      default: begin
        state_next = S_RESET;
      end
    endcase
  end

  assign CW    = cw;
  assign STATE = state;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed bench with a per-cycle expected-sequence model
// and literal pins on lengths and execute control words.
module tb_control_sequencer;

  localparam logic [31:0] IDLE = 32'h10F1_0000;
  localparam logic [31:0] RST  = 32'h00F0_0000;
  localparam logic [31:0] FMAR = 32'h1471_013D;
  localparam logic [31:0] FRD  = 32'hC0F1_8000;
  localparam logic [31:0] FIR  = 32'h02C1_0000;
  localparam logic [31:0] PINC = 32'h00F1_1414;
  localparam int          TMO  = 16;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [31:0] IR_Out;
  logic        MFC;
  logic [3:0]  Flags;
  logic [31:0] CW;
  logic [4:0]  STATE;
  logic        FAULT;

  typedef struct {
    logic [4:0]  st;
    logic [31:0] cw;
    logic        flt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  control_sequencer dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .IR_Out (IR_Out),
    .MFC    (MFC),
    .Flags  (Flags),
    .CW     (CW),
    .STATE  (STATE),
    .FAULT  (FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ARM conditions: pairs share a predicate, the low bit inverts it; 1111 inverts "always".
  function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, p;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: p = z;
      3'd1: p = cc;
      3'd2: p = n;
      3'd3: p = v;
      3'd4: p = cc && !z;
      3'd5: p = (n == v);
      3'd6: p = !z && (n == v);
      default: p = 1'b1;
    endcase
    return p ^ c[0];
  endfunction

  function automatic logic [31:0] model_dp_cw(input logic [31:0] ir);
    logic [31:0] w;
    int op;
    w = IDLE;
    op = int'(ir[24:21]);
    w[3:0] = ir[24:21];
    if (ir[25]) w[5:4] = 2'b10;
    if (op < 8 || op > 11) w[28] = 1'b0;
    w[22] = ~ir[20];
    return w;
  endfunction

  function automatic logic [31:0] model_ls_addr_cw(input logic [31:0] ir);
    logic [31:0] w;
    w = IDLE;
    w[23] = 1'b0;
    w[5:4] = 2'b10;
    w[3:0] = ir[23] ? 4'b0100 : 4'b0010;
    return w;
  endfunction

  // Drive one cycle (mfc: 0, 1 or 2 = random) and queue the expected outputs.
  task automatic step(input logic [4:0] st, input logic [31:0] cw, input int mfc, input logic flt);
    exp_t e;
    MFC = (mfc == 2) ? 1'($urandom_range(0, 1)) : 1'(mfc);
    e.st = st; e.cw = cw; e.flt = flt;
    exp_q.push_back(e);
    @(posedge CLK); #1;
  endtask

  // One instruction from FETCH_MAR; fw / mw are extra MFC-low cycles.
  task automatic run_instr(input logic [31:0] ir, input logic [3:0] flg, input int fw, input int mw);
    IR_Out = ir;
    Flags  = flg;
    step(5'd1, FMAR, 2, 1'b0);
    for (int i = 0; i < fw; i++) step(5'd2, FRD, 0, 1'b0);
    step(5'd2, FRD, 1, 1'b0);
    step(5'd3, FIR, 2, 1'b0);
    step(5'd4, PINC, 2, 1'b0);
    step(5'd5, IDLE, 2, 1'b0);
    Flags = ~flg;
    if (!model_cond(ir[31:28], flg)) return;
    case (ir[27:25])
      3'd0, 3'd1: step(5'd6, model_dp_cw(ir), 2, 1'b0);
      3'd2: begin
        step(5'd7, model_ls_addr_cw(ir), 2, 1'b0);
        if (ir[20]) begin
          for (int i = 0; i < mw; i++) step(5'd8, 32'hD0D1_0000, 0, 1'b0);
          step(5'd8, 32'hD0D1_0000, 1, 1'b0);
          step(5'd9, 32'h00F1_401D, 2, 1'b0);
        end else begin
          for (int i = 0; i < mw; i++) step(5'd10, 32'h92F1_0000, 0, 1'b0);
          step(5'd10, 32'h92F1_0000, 1, 1'b0);
        end
      end
      3'd5: step(5'd11, 32'h00F3_1424, 2, 1'b0);
      default: ;
    endcase
  endtask

  // Zero-wait instruction length and execute-state CW, against literals.
  task automatic pin(input string name, input logic [31:0] ir, input logic [3:0] flg,
                     input int exp_len, input logic [4:0] ex_st, input bit ex_seen,
                     input logic [31:0] ex_cw);
    int n;
    bit seen;
    logic [31:0] got;
    IR_Out = ir; Flags = flg; MFC = 1'b1;
    n = 0; seen = 0; got = '0;
    do begin
      @(posedge CLK); #1;
      n++;
      if (STATE == ex_st) begin seen = 1; got = CW; end
    end while (STATE != 5'd1 && n < 40);
    check({name, "_len"}, 32'(n), 32'(exp_len));
    check({name, "_seen"}, 32'(seen), 32'(ex_seen));
    if (ex_seen) check({name, "_cw"}, got, ex_cw);
  endtask

  // Per-cycle comparison of DUT outputs with the queued model expectations.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("state", 32'(STATE), 32'(e.st));
      check("cw", CW, e.cw);
      check("fault", 32'(FAULT), 32'(e.flt));
    end
  end

  initial begin
    CLR = 1'b1; IR_Out = '0; MFC = 1'b0; Flags = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_state", 32'(STATE), 32'd0);
    check("rst_cw", CW, RST);
    check("rst_fault", 32'(FAULT), 32'd0);
    CLR = 1'b0;
    @(posedge CLK); #1;

    run_instr(32'hE081_0002, 4'b0000, 0, 0);  // ADD
    run_instr(32'hE081_0002, 4'b0000, 3, 0);  // ADD, fetch 3 waits
    run_instr(32'h0A00_0004, 4'b0000, 0, 0);  // BEQ, Z=0
    run_instr(32'h0A00_0004, 4'b0100, 0, 0);  // BEQ, Z=1
    run_instr(32'hE591_0004, 4'b0000, 0, 0);  // LDR
    run_instr(32'hE591_0004, 4'b0000, 1, 2);  // LDR with waits
    run_instr(32'hE511_0004, 4'b1111, 0, 0);  // LDR negative offset
    run_instr(32'hE581_0004, 4'b0000, 0, 1);  // STR
    run_instr(32'hE350_0005, 4'b0000, 0, 0);  // CMP imm, S
    run_instr(32'hF081_0002, 4'b1111, 0, 0);  // never
    run_instr(32'hC081_0002, 4'b1001, 0, 0);  // GT, N=V, Z=0
    run_instr(32'hB081_0002, 4'b1000, 0, 0);  // LT
    run_instr(32'h8081_0002, 4'b0110, 0, 0);  // HI fails
    run_instr(32'h9081_0002, 4'b0110, 0, 0);  // LS passes
    run_instr(32'hE600_0000, 4'b0000, 0, 0);  // class 011 NOP
    run_instr(32'hE800_0000, 4'b0000, 0, 0);  // class 100 NOP
    run_instr(32'hE3A0_1001, 4'b0000, TMO - 1, 0);       // MFC on last allowed cycle
    run_instr(32'hE591_0004, 4'b0000, 0, TMO - 1);
    run_instr(32'hE581_0004, 4'b0000, 0, TMO - 1);

    // Asynchronous reset in the middle of a fetch wait.
    IR_Out = 32'hE081_0002;
    step(5'd1, FMAR, 0, 1'b0);
    MFC = 1'b0;
    #2 CLR = 1'b1;
    #1;
    check("async_state", 32'(STATE), 32'd0);
    check("async_cw", CW, RST);
    @(posedge CLK); #1;
    check("hold_state", 32'(STATE), 32'd0);
    check("hold_fault", 32'(FAULT), 32'd0);
    CLR = 1'b0;
    @(posedge CLK); #1;
    check("rel_state", 32'(STATE), 32'd1);
    check("rel_cw", CW, FMAR);

    pin("add", 32'hE081_0002, 4'b0000, 6, 5'd6, 1'b1, 32'h00F1_0004);
    pin("beq0", 32'h0A00_0004, 4'b0000, 5, 5'd11, 1'b0, 32'h0);
    pin("beq1", 32'h0A00_0004, 4'b0100, 6, 5'd11, 1'b1, 32'h00F3_1424);
    pin("ldr", 32'hE591_0004, 4'b0000, 8, 5'd7, 1'b1, 32'h1071_0024);
    pin("str", 32'hE581_0004, 4'b0000, 7, 5'd10, 1'b1, 32'h92F1_0000);

    // MFC held low on a fetch.
    IR_Out = 32'hE081_0002; Flags = 4'b0000;
    step(5'd1, FMAR, 2, 1'b0);
`ifdef CU_MFC_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) step(5'd2, FRD, 0, 1'b0);
    for (int i = 0; i < 6; i++) step(5'd12, IDLE, 2, 1'b1);
    check("tmo_state", 32'(STATE), 32'd12);
    check("tmo_fault", 32'(FAULT), 32'd1);
`else
    for (int i = 0; i < 100; i++) step(5'd2, FRD, 0, 1'b0);
    check("nto_state", 32'(STATE), 32'd2);
    check("nto_fault", 32'(FAULT), 32'd0);
`endif
    CLR = 1'b1;
    #1;
    check("clr_state", 32'(STATE), 32'd0);
    check("clr_fault", 32'(FAULT), 32'd0);
    @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcoded Moore sequencer that drives the 32-bit control word of `data_path`, replacing hand-written control stimulus in benches. It steps through fetch (MAR<-PC, memory read, IR<-MDR, PC<-PC+4), then decode and execute. Execute handles three classes:
- data-processing, register and immediate forms;
- word load/store with immediate offset;
- branch.

It evaluates the ARM condition field against `Flags` and stalls on memory until `MFC`. It sits beside `data_path`: `CW` feeds the data path's control inputs and `IR_Out`/`MFC`/`Flags` return.

## Interface
- `MFC_TIMEOUT`, 16, cycles to wait for `MFC` before faulting. Used only with `CU_MFC_TIMEOUT_EN`.

Ports:
- `CLK`  in  1  clock, rising edge.
- `CLR`  in  1  reset, asynchronous, active-high.
- `IR_Out`  in  32  instruction register contents.
- `MFC`  in  1  memory function complete.
- `Flags`  in  4  {N,Z,C,V}, bit3 = N.
- `CW`  out  32  control word. Field map:
  - bit 31 `MFA`, 30 `RW_RAM`, 29 `SALU`, 28 `RF_RW`;
  - bit 27 `SSAB`, 26 `SSOP`, 25 `SMA`, 24 `STA`;
  - bits 23..17 `MAR_EN`, `SR_EN`, `MDR_EN`, `IR_EN`, `SHT_EN`, `ISE_EN`, `SGN_EN`;
  - bit 16 `CLR_N`;
  - 15:14 `DSS`, 13:12 `WRA`, 11:10 `SRA`, 9:8 `SRB`, 7:6 `SISE`, 5:4 `SALUB`, 3:0 `ALUA`.
  - Polarity: bits 23..20 and bit 16 are active-low. `RF_RW` = 0 means register write.
- `STATE`  out  5  current state code, for debug.
- `FAULT`  out  1  memory timeout, sticky.

## Operation
- The state register updates on posedge `CLK`. `CW` and `STATE` are combinational from the state register and `IR_Out`.
- `IDLE_CW` = 0x10F10000: no enables, no write, `CLR_N` = 1. Every state not listed uses `IDLE_CW`.
- States, with code and `CW`:
  - 0 RESET: 0x00F00000 (clears data path).
  - 1 FETCH_MAR: 0x1471013D.
  - 2 FETCH_READ: 0xC0F18000.
  - 3 FETCH_IR: 0x02C10000.
  - 4 PC_INC: 0x00F11414.
  - 5 DECODE: `IDLE_CW`.
  - 6 DP_EXEC, 7 LS_ADDR, 8 LS_READ, 9 LS_LOAD, 10 LS_WRITE, 11 BR_EXEC, 12 FAULT.
- Fixed transitions:
  - RESET->FETCH_MAR.
  - FETCH_MAR->FETCH_READ.
  - FETCH_READ holds until `MFC`=1, then ->FETCH_IR.
  - FETCH_IR->PC_INC->DECODE.
- DECODE: the condition on `IR_Out[31:28]` uses standard ARM semantics. Codes 1110 and 1111 are always/never.
  - Condition false or 1111 -> FETCH_MAR.
  - Otherwise on `IR_Out[27:25]`: 000/001 -> DP_EXEC; 010 -> LS_ADDR; 101 -> BR_EXEC; any other value -> FETCH_MAR (NOP).
- DP_EXEC `CW` overrides on `IDLE_CW`:
  - `ALUA` = `IR[24:21]`.
  - `SALUB` = 10 if `IR[25]`, else 00.
  - `RF_RW` = 0, except opcodes 10xx (TST/TEQ/CMP/CMN) keep 1.
  - `SR_EN` = ~`IR[20]`.
  - Next state: ->FETCH_MAR.
- LS_ADDR: MAR<-Rn ± imm.
  - `ALUA` = 0100 if `IR[23]`, else 0010.
  - `SALUB` = 10, `MAR_EN` = 0.
  - Next state: ->LS_READ if `IR[20]`, else ->LS_WRITE.
- LS_READ: `MFA` = 1, `RW_RAM` = 1, `MDR_EN` = 0. Holds until `MFC`, then ->LS_LOAD.
- LS_LOAD: Rd<-MDR.
  - `RF_RW` = 0, `DSS` = 01, `ALUA` = 1101, `SALUB` = 01.
  - Next state: ->FETCH_MAR.
- LS_WRITE: `MFA` = 1, `RW_RAM` = 0, `SMA` = 1. Holds until `MFC`, then ->FETCH_MAR.
- BR_EXEC: PC<-PC+sext(offset).
  - `RF_RW` = 0, `WRA` = 01, `SRA` = 01, `SALUB` = 10, `ALUA` = 0100, `SGN_EN` = 1.
  - `IR[24]` (link) is ignored.
  - Next state: ->FETCH_MAR.
- FAULT: `IDLE_CW`, with `FAULT` = 1. Exit only via `CLR`.

## Timing
- `CLR` = 1 asynchronously forces state RESET, `CW` = 0x00F00000, `STATE` = 0, `FAULT` = 0. These hold while `CLR` is asserted.
- The first posedge after `CLR` falls enters FETCH_MAR.
- Reset mid-operation, including during a memory wait, abandons the instruction immediately.
- With zero-wait memory (`MFC` high on the first wait cycle), posedge to posedge:
  - fetch+decode: 5 cycles;
  - DP and branch: 6;
  - store: 7;
  - load: 8;
  - condition fail: 5.
- Each extra wait cycle adds 1.
- `MFC` is sampled only in FETCH_READ, LS_READ and LS_WRITE; in other states it is ignored.
- `MFA` stays asserted for every cycle of a wait state.
- `Flags` are sampled in DECODE only. An `SR` update in DP_EXEC affects the next instruction.

## Configuration
- `CU_MFC_TIMEOUT_EN` defined:
  - A 5-bit counter clears on entry to each wait state and increments every cycle in which `MFC` = 0.
  - When the counter reaches `MFC_TIMEOUT` in a wait state without `MFC` -> FAULT.
  - `FAULT` = 1 sticky.
  - `MFC` on the same edge that the count reaches `MFC_TIMEOUT` wins: no fault.
- Undefined: wait states hold indefinitely. `FAULT` is tied 0 and state 12 is unreachable.

## Test plan
- Pulse `CLR` mid-FETCH_READ -> `CW` = 0x00F00000 and `STATE` = 0 without waiting for a clock. The 1st posedge after release gives `STATE` = 1 and `CW` = 0x1471013D.
- `MFC` delayed 3 cycles on fetch -> `STATE` stays 2 for 4 cycles with `CW[31]` = 1, then follows 3, 4, 5.
- `IR_Out` = 0xE0810002 (ADD R0,R1,R2), `Flags` = 0 -> DP_EXEC with `ALUA` = 0100, `SALUB` = 00, `RF_RW` = 0; 6 cycles total.
- `IR_Out` = 0x0A000004 (BEQ) with Z = 0 -> DECODE->FETCH_MAR, no BR_EXEC. With Z = 1 -> BR_EXEC with `CW[5:0]` = 0x24.
- `IR_Out` = 0xE5910004 (LDR), `MFC` immediate -> states 7, 8, 9, load total 8 cycles. `IR_Out` = 0xE5810004 (STR) -> states 7, 10, `RW_RAM` = 0 in state 10.
- With `CU_MFC_TIMEOUT_EN`, `MFC` held 0 -> `STATE` = 12 and `FAULT` = 1 16 cycles after entering FETCH_READ, held until `CLR`. Without the macro, the same stimulus gives no fault after 100 cycles.
